// File: rtl/char_move_pkg.sv
// Shared types, widths and placement helpers for the bottom-row character movers.
package char_move_pkg;

  typedef enum logic [1:0] {ALIVE = 2'd0, DYING = 2'd1, RESPAWN = 2'd2} char_st_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_LEFT = 2'd1, DIR_RIGHT = 2'd2} dir_t;

  localparam int X_W   = 11;
  localparam int POS_W = 12;
  localparam int SPD_W = 3;

  localparam int DEF_SCREEN_W   = 640;
  localparam int DEF_CHAR_WIDTH = 20;
  localparam int MAX_X          = DEF_SCREEN_W - DEF_CHAR_WIDTH;

  function automatic int spawn_x(input int idx, input int x0, input int step);
    return x0 + idx * step;
  endfunction

  function automatic int max_x(input int screen_w, input int char_w);
    return screen_w - char_w;
  endfunction

endpackage

// File: rtl/char_move_chan.sv
// One character channel: ALIVE/DYING/RESPAWN FSM, frame-based acceleration and
// clamped horizontal position.
module char_move_chan
  import char_move_pkg::*;
#(
  parameter int SPAWN_X        = 160,
  parameter int MAX_XP         = 620,
  parameter int MAX_SPEED      = 4,
  parameter int ACCEL_FRAMES   = 4,
  parameter int RESPAWN_FRAMES = 60,
  parameter int BLINK_FRAMES   = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           sof_i,
  input  logic           new_level_i,
  input  logic           left_press_i,
  input  logic           right_press_i,
  input  logic           left_crash_i,
  input  logic           right_crash_i,
  input  logic           hit_i,
  output logic [X_W-1:0] x_o,
  output logic           alive_o,
  output logic           visible_o
);

  localparam int ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FRM_W = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [ACC_W-1:0]        ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);
  localparam logic [BLK_W-1:0]        BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [FRM_W-1:0]        FRM_LAST = FRM_W'(RESPAWN_FRAMES - 1);
  localparam logic [SPD_W-1:0]        SPD_MAX  = SPD_W'(MAX_SPEED);
  localparam logic [X_W-1:0]          X_SPAWN  = X_W'(SPAWN_X);
  localparam logic [X_W-1:0]          X_LIMIT  = X_W'(MAX_XP);
  localparam logic signed [POS_W-1:0] X_MAX_S  = POS_W'(MAX_XP);

  char_st_t          state_q, state_d;
  dir_t              dir_q, dir_d, dir_s, mv_dir_s;
  logic [X_W-1:0]    x_q, x_d, mv_x_s;
  logic [SPD_W-1:0]  spd_q, spd_d, mv_spd_s;
  logic [ACC_W-1:0]  acc_q, acc_d, mv_acc_s;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [FRM_W-1:0]  frm_q, frm_d;
  logic              vis_q, vis_d, alive_q, alive_d;
  logic              crash_s;
  logic signed [POS_W-1:0] pos_s, step_s;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ALIVE;
      dir_q   <= DIR_NONE;
      x_q     <= X_SPAWN;
      spd_q   <= 3'd0;
      acc_q   <= {ACC_W{1'b0}};
      blk_q   <= {BLK_W{1'b0}};
      frm_q   <= {FRM_W{1'b0}};
      vis_q   <= 1'b1;
      alive_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      spd_q   <= spd_d;
      acc_q   <= acc_d;
      blk_q   <= blk_d;
      frm_q   <= frm_d;
      vis_q   <= vis_d;
      alive_q <= alive_d;
    end
  end

  // Next-state logic; newLevel overrides everything below reset.
  always_comb begin
    state_d = state_q;
    if (new_level_i) begin
      state_d = ALIVE;
    end else begin
      case (state_q)
        ALIVE:   state_d = hit_i ? DYING : ALIVE;
        DYING:   state_d = (sof_i && (frm_q == FRM_LAST)) ? RESPAWN : DYING;
        RESPAWN: state_d = ALIVE;
        default: state_d = ALIVE;
      endcase
    end
  end

  assign crash_s = ((dir_s == DIR_RIGHT) && right_crash_i) ||
                   ((dir_s == DIR_LEFT) && left_crash_i);

  // Frame move candidate: direction, acceleration, crash block and wall clamp.
  always_comb begin
    dir_s = DIR_NONE;
    if (right_press_i && !left_press_i) begin
      dir_s = DIR_RIGHT;
    end else if (left_press_i && !right_press_i) begin
      dir_s = DIR_LEFT;
    end else begin
      dir_s = DIR_NONE;
    end
    mv_dir_s = dir_s;
    mv_acc_s = acc_q;
    mv_spd_s = spd_q;
    if (dir_s == DIR_NONE) begin
      mv_spd_s = 3'd0;
      mv_acc_s = {ACC_W{1'b0}};
    end else if (dir_s != dir_q) begin
      mv_spd_s = 3'd1;
      mv_acc_s = {ACC_W{1'b0}};
    end else if (acc_q == ACC_LAST) begin
      mv_acc_s = {ACC_W{1'b0}};
      mv_spd_s = (spd_q >= SPD_MAX) ? SPD_MAX : spd_q + 3'd1;
    end else begin
      mv_acc_s = acc_q + ACC_W'(1);
      mv_spd_s = spd_q;
    end
    step_s = $signed({{(POS_W - SPD_W){1'b0}}, mv_spd_s});
    if (dir_s == DIR_LEFT) begin
      pos_s = $signed({1'b0, x_q}) - step_s;
    end else begin
      pos_s = $signed({1'b0, x_q}) + step_s;
    end
    mv_x_s = x_q;
    if (crash_s || (pos_s < 12'sd0) || (pos_s > X_MAX_S)) begin
      mv_spd_s = 3'd0;
      mv_acc_s = {ACC_W{1'b0}};
      mv_dir_s = DIR_NONE;
      if (crash_s) begin
        mv_x_s = x_q;
      end else if (pos_s < 12'sd0) begin
        mv_x_s = {X_W{1'b0}};
      end else begin
        mv_x_s = X_LIMIT;
      end
    end else begin
      mv_x_s = pos_s[X_W-1:0];
    end
  end

  // Per-state register updates.
  always_comb begin
    x_d   = x_q;
    spd_d = spd_q;
    acc_d = acc_q;
    dir_d = dir_q;
    blk_d = blk_q;
    frm_d = frm_q;
    vis_d = vis_q;
    if (new_level_i) begin
      x_d   = X_SPAWN;
      spd_d = 3'd0;
      acc_d = {ACC_W{1'b0}};
      dir_d = DIR_NONE;
      blk_d = {BLK_W{1'b0}};
      frm_d = {FRM_W{1'b0}};
      vis_d = 1'b1;
    end else begin
      case (state_q)
        ALIVE: begin
          if (hit_i) begin
            spd_d = 3'd0;
            acc_d = {ACC_W{1'b0}};
            dir_d = DIR_NONE;
            blk_d = {BLK_W{1'b0}};
            frm_d = {FRM_W{1'b0}};
            vis_d = 1'b0;
          end else if (sof_i) begin
            x_d   = mv_x_s;
            spd_d = mv_spd_s;
            acc_d = mv_acc_s;
            dir_d = mv_dir_s;
          end else begin
            x_d = x_q;
          end
        end
        DYING: begin
          if (sof_i && (frm_q == FRM_LAST)) begin
            x_d   = X_SPAWN;
            frm_d = {FRM_W{1'b0}};
            blk_d = {BLK_W{1'b0}};
            vis_d = 1'b1;
          end else if (sof_i) begin
            frm_d = frm_q + FRM_W'(1);
            if (blk_q == BLK_LAST) begin
              blk_d = {BLK_W{1'b0}};
              vis_d = ~vis_q;
            end else begin
              blk_d = blk_q + BLK_W'(1);
            end
          end else begin
            frm_d = frm_q;
          end
        end
        RESPAWN: vis_d = 1'b1;
        default: vis_d = 1'b1;
      endcase
    end
    alive_d = (state_d == ALIVE);
  end

  assign x_o       = x_q;
  assign alive_o   = alive_q;
  assign visible_o = vis_q;

endmodule

// File: rtl/char_move_multi.sv
// Multi-player bottom-row motion controller: one independent char_move_chan per
// player, each with its own spawn column.
module char_move_multi
  import char_move_pkg::*;
#(
  parameter int NUM_CHARS      = 2,
  parameter int CHAR_HIGHT     = 32,
  parameter int CHAR_WIDTH     = 20,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int INITIAL_X0     = 160,
  parameter int SPAWN_STEP     = 320,
  parameter int MAX_SPEED      = 4,
  parameter int ACCEL_FRAMES   = 4,
  parameter int RESPAWN_FRAMES = 60,
  parameter int BLINK_FRAMES   = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_of_frame_i,
  input  logic                            new_level_i,
  input  logic [NUM_CHARS-1:0]            left_press_i,
  input  logic [NUM_CHARS-1:0]            right_press_i,
  input  logic [NUM_CHARS-1:0]            left_crash_i,
  input  logic [NUM_CHARS-1:0]            right_crash_i,
  input  logic [NUM_CHARS-1:0]            hit_i,
  output logic [NUM_CHARS-1:0][X_W-1:0]   top_left_x_o,
  output logic [NUM_CHARS-1:0][X_W-1:0]   top_left_y_o,
  output logic [NUM_CHARS-1:0]            alive_o,
  output logic [NUM_CHARS-1:0]            visible_o
);

  localparam int             LIMIT_X = max_x(SCREEN_W, CHAR_WIDTH);
  localparam logic [X_W-1:0] ROW_Y   = X_W'(SCREEN_H - 1 - CHAR_HIGHT);

  for (genvar g = 0; g < NUM_CHARS; g++) begin : gen_chan
    char_move_chan #(
      .SPAWN_X        (spawn_x(g, INITIAL_X0, SPAWN_STEP)),
      .MAX_XP         (LIMIT_X),
      .MAX_SPEED      (MAX_SPEED),
      .ACCEL_FRAMES   (ACCEL_FRAMES),
      .RESPAWN_FRAMES (RESPAWN_FRAMES),
      .BLINK_FRAMES   (BLINK_FRAMES)
    ) u_chan (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .sof_i         (start_of_frame_i),
      .new_level_i   (new_level_i),
      .left_press_i  (left_press_i[g]),
      .right_press_i (right_press_i[g]),
      .left_crash_i  (left_crash_i[g]),
      .right_crash_i (right_crash_i[g]),
      .hit_i         (hit_i[g]),
      .x_o           (top_left_x_o[g]),
      .alive_o       (alive_o[g]),
      .visible_o     (visible_o[g])
    );
    assign top_left_y_o[g] = ROW_Y;
  end

endmodule

// File: tb/tb_char_move_multi.sv
// Randomized bench for char_move_multi against a frame-level behavioural model.
module tb_char_move_multi;

  localparam int NC = 2, CH = 32, CW = 20, SW = 640, SH = 480;
  localparam int X0 = 160, STEP = 320, MS = 4, AF = 4, RF = 60, BF = 4;
  localparam int MAXX = SW - CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sof, nl;
  logic [NC-1:0] lp, rp, lc, rc, hit;
  logic [NC-1:0][10:0] tlx, tly;
  logic [NC-1:0] alive, vis;

  int total = 0;
  int bad = 0;

  // model: st 0=alive 1=dying 2=respawn; run = current direction run length in frames
  int m_st[NC], m_x[NC], m_rdir[NC], m_rlen[NC], m_dfr[NC];
  bit m_vis[NC];

  char_move_multi #(
    .NUM_CHARS(NC), .CHAR_HIGHT(CH), .CHAR_WIDTH(CW), .SCREEN_W(SW), .SCREEN_H(SH),
    .INITIAL_X0(X0), .SPAWN_STEP(STEP), .MAX_SPEED(MS), .ACCEL_FRAMES(AF),
    .RESPAWN_FRAMES(RF), .BLINK_FRAMES(BF)
  ) dut (
    .clk_i(clk), .reset_i(rst), .start_of_frame_i(sof), .new_level_i(nl),
    .left_press_i(lp), .right_press_i(rp), .left_crash_i(lc), .right_crash_i(rc),
    .hit_i(hit), .top_left_x_o(tlx), .top_left_y_o(tly), .alive_o(alive), .visible_o(vis)
  );

  function automatic int spawn(input int i);
    return X0 + i * STEP;
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int d, spd, nx;
    for (int i = 0; i < NC; i++) begin
      if (rst || nl) begin
        m_st[i] = 0; m_x[i] = spawn(i); m_vis[i] = 1'b1;
        m_rdir[i] = 0; m_rlen[i] = 0; m_dfr[i] = 0;
      end else if (m_st[i] == 0) begin
        if (hit[i]) begin
          m_st[i] = 1; m_dfr[i] = 0; m_vis[i] = 1'b0; m_rdir[i] = 0;
        end else if (sof) begin
          d = (rp[i] && !lp[i]) ? 1 : ((lp[i] && !rp[i]) ? -1 : 0);
          if (d == 0) begin
            m_rdir[i] = 0; m_rlen[i] = 0;
          end else begin
            if (d != m_rdir[i]) begin
              m_rdir[i] = d; m_rlen[i] = 0;
            end else begin
              m_rlen[i]++;
            end
            spd = 1 + m_rlen[i] / AF;
            if (spd > MS) spd = MS;
            if ((d > 0 && rc[i]) || (d < 0 && lc[i])) begin
              m_rdir[i] = 0;
            end else begin
              nx = m_x[i] + d * spd;
              if (nx < 0) begin nx = 0; m_rdir[i] = 0; end
              else if (nx > MAXX) begin nx = MAXX; m_rdir[i] = 0; end
              m_x[i] = nx;
            end
          end
        end
      end else if (m_st[i] == 1) begin
        if (sof) begin
          m_dfr[i]++;
          if (m_dfr[i] == RF) begin
            m_st[i] = 2; m_x[i] = spawn(i); m_vis[i] = 1'b1;
          end else begin
            m_vis[i] = ((m_dfr[i] / BF) % 2) == 1;
          end
        end
      end else begin
        m_st[i] = 0; m_vis[i] = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit s, input bit n, input logic [NC-1:0] l, input logic [NC-1:0] r,
                     input logic [NC-1:0] lcr, input logic [NC-1:0] rcr,
                     input logic [NC-1:0] h, input bit rs);
    sof = s; nl = n; lp = l; rp = r; lc = lcr; rc = rcr; hit = h; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NC; i++) begin
      check_val($sformatf("x[%0d]", i), int'(tlx[i]), m_x[i]);
      check_val($sformatf("alive[%0d]", i), int'(alive[i]), (m_st[i] == 0) ? 1 : 0);
      check_val($sformatf("vis[%0d]", i), int'(vis[i]), int'(m_vis[i]));
    end
  endtask

  task automatic frame(input logic [NC-1:0] l, input logic [NC-1:0] r,
                       input logic [NC-1:0] lcr, input logic [NC-1:0] rcr);
    cyc(1'b1, 1'b0, l, r, lcr, rcr, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, l, r, lcr, rcr, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, l, r, lcr, rcr, 2'b00, 1'b0);
  endtask

  logic [NC-1:0] kl, kr;

  initial begin
    rst = 1'b1; sof = 1'b0; nl = 1'b0; lp = '0; rp = '0; lc = '0; rc = '0; hit = '0;
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    check_val("rst_x0", int'(tlx[0]), 160);
    check_val("rst_x1", int'(tlx[1]), 480);
    check_val("rst_y0", int'(tly[0]), 447);
    check_val("rst_y1", int'(tly[1]), 447);
    check_val("rst_alive", int'(alive), 3);
    check_val("rst_vis", int'(vis), 3);

    // acceleration: 1,1,1,1,2,2,2,2,3,3,3,3
    for (int f = 0; f < 12; f++) frame(2'b00, 2'b01, 2'b00, 2'b00);
    check_val("accel_x0", int'(tlx[0]), 184);
    check_val("accel_x1", int'(tlx[1]), 480);

    // crash blocks, release restarts at speed 1
    frame(2'b00, 2'b01, 2'b00, 2'b01);
    frame(2'b00, 2'b01, 2'b00, 2'b01);
    check_val("crash_hold", int'(tlx[0]), 184);
    frame(2'b00, 2'b01, 2'b00, 2'b00);
    check_val("crash_rel1", int'(tlx[0]), 185);
    frame(2'b00, 2'b01, 2'b00, 2'b00);
    check_val("crash_rel2", int'(tlx[0]), 186);

    // hit on ch1, full blink/respawn sequence
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0);
    check_val("hit_alive1", int'(alive[1]), 0);
    for (int f = 0; f < RF; f++) frame(2'b00, 2'b00, 2'b00, 2'b00);
    check_val("resp_x1", int'(tlx[1]), 480);
    check_val("resp_alive", int'(alive), 3);
    check_val("resp_vis", int'(vis), 3);

    // newLevel mid-DYING on ch1 while ch0 moves, with hit on ch0 the same edge
    for (int f = 0; f < 3; f++) frame(2'b00, 2'b01, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0);
    for (int f = 0; f < 5; f++) frame(2'b00, 2'b01, 2'b00, 2'b00);
    cyc(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
    check_val("nl_x0", int'(tlx[0]), 160);
    check_val("nl_x1", int'(tlx[1]), 480);
    check_val("nl_alive", int'(alive), 3);
    check_val("nl_vis", int'(vis), 3);

    // randomized traffic with long key holds so walls get reached
    kl = '0; kr = '0;
    for (int c = 0; c < 15000; c++) begin
      logic [NC-1:0] h, lcr, rcr;
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 79) == 0) begin
          case ($urandom_range(0, 3))
            0: begin kl[i] = 1'b1; kr[i] = 1'b0; end
            1: begin kl[i] = 1'b0; kr[i] = 1'b1; end
            2: begin kl[i] = 1'b1; kr[i] = 1'b1; end
            default: begin kl[i] = 1'b0; kr[i] = 1'b0; end
          endcase
        end
        h[i]   = ($urandom_range(0, 249) == 0);
        lcr[i] = ($urandom_range(0, 9) == 0);
        rcr[i] = ($urandom_range(0, 9) == 0);
      end
      cyc((c % 3) == 0, $urandom_range(0, 1999) == 0, kl, kr, lcr, rcr, h,
          $urandom_range(0, 5999) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_move_multi.md
# char_move_multi

Per-player horizontal motion controller for 1..N characters on the bottom row of the playfield. It is the multi-channel successor of the single-character mover. Each channel adds frame-based acceleration up to a configurable top speed, wall/obstacle crash blocking, and a hit → freeze/blink → respawn sequence. It sits between the keyboard decoder and the character sprite/drawing and collision logic, and outputs per-player top-left coordinates plus alive/visible flags.

## Interface
- NUM_CHARS, 2, number of independent character channels (1..4)
- CHAR_HIGHT, 32, sprite height in pixels
- CHAR_WIDTH, 20, sprite width in pixels
- SCREEN_W, 640, playfield width
- SCREEN_H, 480, playfield height
- INITIAL_X0, 160, spawn X of channel 0
- SPAWN_STEP, 320, spawn X increment per channel (spawn X_i = INITIAL_X0 + i*SPAWN_STEP)
- MAX_SPEED, 4, top speed in pixels/frame (1..7)
- ACCEL_FRAMES, 4, consecutive held frames per speed increment
- RESPAWN_FRAMES, 60, frames frozen after a hit
- BLINK_FRAMES, 4, frames per visible toggle while frozen
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at frame start
- newLevel  in  1  one-cycle pulse: respawn all channels
- leftPress  in  NUM_CHARS  left key held, per channel
- rightPress  in  NUM_CHARS  right key held, per channel
- leftCrash  in  NUM_CHARS  obstacle touching the left side
- rightCrash  in  NUM_CHARS  obstacle touching the right side
- hit  in  NUM_CHARS  character struck by a ball (any cycle)
- topLeftX  out  NUM_CHARS x 11  sprite top-left X
- topLeftY  out  NUM_CHARS x 11  sprite top-left Y, constant SCREEN_H-1-CHAR_HIGHT
- alive  out  NUM_CHARS  1 = ALIVE state
- visible  out  NUM_CHARS  1 = draw sprite

## Operation
- Per-channel FSM states: ALIVE, DYING, RESPAWN.
- ALIVE: position, speed, and direction update only on cycles with startOfFrame=1.
- Effective direction: right if rightPress&!leftPress; left if leftPress&!rightPress; otherwise none. Both keys held counts as none.
- Speed 0..MAX_SPEED, 3-bit, with a held-frame counter:
  - none → speed=0, counter=0.
  - Direction differs from the previous frame → speed=1, counter=0.
  - Same direction → counter++. When counter reaches ACCEL_FRAMES-1, speed saturates-increments and counter clears.
- Crash: moving right with rightCrash=1, or moving left with leftCrash=1 → no move, speed=0, counter=0.
- Position arithmetic is 12-bit signed: X_new = X ± speed, clamped to [0, SCREEN_W-CHAR_WIDTH]. A clamp also forces speed=0.
- hit=1 in ALIVE (any cycle) → DYING on the next cycle. Position freezes, speed=0, visible=0, frame counter=0.
- DYING: counts startOfFrame pulses. visible toggles every BLINK_FRAMES frames. After RESPAWN_FRAMES frames → RESPAWN. hit is ignored.
- RESPAWN: one cycle. X=spawn X_i, speed=0, visible=1. Next state is ALIVE.
- newLevel=1: every channel goes to spawn X_i, speed=0, ALIVE, visible=1 on the next cycle. newLevel has priority over hit, startOfFrame, and the DYING count.
- Channels are fully independent. No inter-character collision is handled inside this block; it arrives through the crash inputs.

## Timing
- Reset (synchronous, same edge) gives: topLeftX[i]=spawn X_i, topLeftY=SCREEN_H-1-CHAR_HIGHT, alive=1, visible=1, speed=0, state ALIVE.
- All outputs are registered. A frame update is visible one cycle after the startOfFrame edge.
- Priority on a single edge: reset > newLevel > hit > startOfFrame movement.
- hit together with startOfFrame on the same cycle: the channel enters DYING and does not move that frame.
- RESPAWN_FRAMES counter width is $clog2(RESPAWN_FRAMES+1). BLINK counter is separate.
- Mid-DYING reset or newLevel: immediate respawn; counters clear.

## Structure
- Package char_move_pkg holds:
  - typedef enum logic [1:0] {ALIVE, DYING, RESPAWN} char_st_t;
  - localparam functions spawn_x(i) and MAX_X = SCREEN_W-CHAR_WIDTH.
- Sub-module char_move_chan holds one channel: FSM, speed/accel counter, and position. The top level instantiates it in a generate loop over NUM_CHARS and passes SPAWN_X per instance.

## Test plan
- Reset, then NUM_CHARS=2 → X={160,480}, Y=447, alive=2'b11, visible=2'b11.
- Ch0 rightPress held 12 frames → X increments per frame: 1,1,1,1,2,2,2,2,3,3,3,3; X=184. Ch1 is unchanged.
- Ch0 at X=618 moving right at speed 4 → X=620 and speed 0. leftPress at X=2 with speed 3 → X=0.
- rightCrash[0]=1 while moving right → X holds, speed resets. Releasing the crash restarts at speed 1.
- hit[1] pulse → alive[1]=0 on the next cycle. visible[1] toggles every 4 frames. After 60 frames, X=480, alive=1, visible=1.
- newLevel during DYING on ch1 while ch0 moves → both channels at spawn X next cycle, alive=2'b11. hit+newLevel on the same cycle → stays ALIVE.
